// File: rtl/hub75_pkg.sv
// Shared HUB75 framebuffer definitions: geometry, word packing and ingest FSM states.
// Used by both the write-side ingest stage and the scan-out side.
package hub75_pkg;

  localparam int FB_ADDR_W = 14;
  localparam int FB_DATA_W = 20;
  localparam int FB_PIXELS = 16384;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_R         = 3'd1,
    ST_G         = 3'd2,
    ST_B         = 3'd3,
    ST_SWAP_WAIT = 3'd4
  } ingest_state_e;

  // Keeps the top 7 bits of R and G and the top 6 bits of B.
  function automatic logic [FB_DATA_W-1:0] pack_rgb888(input logic [7:0] r,
                                                       input logic [7:0] g,
                                                       input logic [7:0] b);
    return {r[7:1], g[7:1], b[7:2]};
  endfunction

endpackage

// File: rtl/hub75_ingest.sv
// RGB888 byte stream to framebuffer writer. Flips the double-buffer select only at a
// display frame boundary, so the scan-out side never shows a partly written frame.
module hub75_ingest
  import hub75_pkg::*;
#(
  parameter int NUM_PIXELS = FB_PIXELS,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              disp_frame_start,
  output logic [DATA_W-1:0] fb_wdata,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic              fb_we,
  output logic              fb_selection,
  output logic              frame_done,
  output logic              err_sof
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  ingest_state_e     state_r;
  logic [ADDR_W-1:0] pix_cnt_r;
  logic [7:0]        r_byte_r;
  logic [7:0]        g_byte_r;
  logic              accept_s;
  logic              last_pix_s;
  logic              sof_abort_s;

  assign accept_s    = s_valid & s_ready;
  assign last_pix_s  = (pix_cnt_r == LAST_PIX);
  // An SOF is only legitimate where pixel 0 would start anyway.
  assign sof_abort_s = s_sof & ~((state_r == ST_R) & (pix_cnt_r == {ADDR_W{1'b0}}));

  // Ingest FSM with pixel counter, byte holding registers and registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pix_cnt_r    <= {ADDR_W{1'b0}};
      r_byte_r     <= 8'd0;
      g_byte_r     <= 8'd0;
      s_ready      <= 1'b0;
      fb_we        <= 1'b0;
      fb_waddr     <= {ADDR_W{1'b0}};
      fb_wdata     <= {DATA_W{1'b0}};
      fb_selection <= 1'b0;
      frame_done   <= 1'b0;
      err_sof      <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      s_ready    <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && s_sof) begin
            r_byte_r  <= s_data;
            pix_cnt_r <= {ADDR_W{1'b0}};
            state_r   <= ST_G;
          end
        end
        ST_R, ST_G, ST_B: begin
          if (accept_s && sof_abort_s) begin
            err_sof   <= 1'b1;
            r_byte_r  <= s_data;
            pix_cnt_r <= {ADDR_W{1'b0}};
            state_r   <= ST_G;
          end else if (accept_s) begin
            case (state_r)
              ST_R: begin
                r_byte_r <= s_data;
                state_r  <= ST_G;
              end
              ST_G: begin
                g_byte_r <= s_data;
                state_r  <= ST_B;
              end
              ST_B: begin
                fb_we    <= 1'b1;
                fb_waddr <= pix_cnt_r;
                fb_wdata <= pack_rgb888(r_byte_r, g_byte_r, s_data);
                if (last_pix_s) begin
                  s_ready <= 1'b0;
                  state_r <= ST_SWAP_WAIT;
                end else begin
                  pix_cnt_r <= pix_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_r   <= ST_R;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_SWAP_WAIT: begin
          // A boundary pulse coinciding with the final write is too early to be safe.
          if (disp_frame_start && !fb_we) begin
            fb_selection <= ~fb_selection;
            frame_done   <= 1'b1;
            pix_cnt_r    <= {ADDR_W{1'b0}};
            state_r      <= ST_IDLE;
          end else begin
            s_ready <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_ingest.sv
// Scoreboard bench for hub75_ingest with a 4-pixel frame.
module tb_hub75_ingest;

  localparam int NPIX = 4;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_ready;
  logic        disp_frame_start = 1'b0;
  logic [19:0] fb_wdata;
  logic [13:0] fb_waddr;
  logic        fb_we;
  logic        fb_selection;
  logic        frame_done;
  logic        err_sof;

  hub75_ingest #(.NUM_PIXELS(NPIX)) dut (
    .sys_clk(sys_clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .disp_frame_start(disp_frame_start), .fb_wdata(fb_wdata),
    .fb_waddr(fb_waddr), .fb_we(fb_we), .fb_selection(fb_selection),
    .frame_done(frame_done), .err_sof(err_sof)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [13:0] addr;
    logic [19:0] data;
  } wr_t;

  wr_t        sb_q[$];
  wr_t        mon_e;
  int         we_cyc_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_we = 0;
  int         n_err_sof = 0;
  int         n_done = 0;
  int         sof_cyc = 0;
  bit         gaps = 1'b0;
  logic [7:0] frm [12];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] exp_pack(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r[7:1], g[7:1], b[7:2]};
  endfunction

  // Output monitor: every write is popped from the scoreboard and compared.
  always @(negedge sys_clk) begin
    if (fb_we) begin
      n_we++;
      we_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("waddr", 32'(fb_waddr), 32'(mon_e.addr));
        check("wdata", 32'(fb_wdata), 32'(mon_e.data));
      end
    end
    if (err_sof) n_err_sof++;
    if (frame_done) n_done++;
  end

  task automatic send_byte(input logic [7:0] d, input logic sof);
    int guard;
    int g;
    g = 0;
    while (gaps && ($urandom_range(1, 0) == 1) && g < 8) begin
      s_valid = 1'b0;
      @(posedge sys_clk); #1;
      g++;
    end
    s_data = d; s_sof = sof; s_valid = 1'b1;
    guard = 0;
    while (!s_ready && guard < 50) begin
      @(posedge sys_clk); #1;
      guard++;
    end
    if (!s_ready) check("ready_timeout", 32'd0, 32'd1);
    else if (sof) sof_cyc = cyc;
    @(posedge sys_clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input logic sof_first);
    for (int i = lo; i <= hi; i++) begin
      send_byte(frm[i], (i == lo) && sof_first);
      if (i % 3 == 2)
        sb_q.push_back(wr_t'{addr: 14'(i / 3), data: exp_pack(frm[i-2], frm[i-1], frm[i])});
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 12; i++) frm[i] = 8'($urandom_range(255, 0));
  endtask

  task automatic pulse_disp();
    disp_frame_start = 1'b1;
    @(posedge sys_clk); #1;
    disp_frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_we"}, 32'(fb_we), 32'd0);
    check({tag, "_waddr"}, 32'(fb_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(fb_wdata), 32'd0);
    check({tag, "_sel"}, 32'(fb_selection), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(err_sof), 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge sys_clk); #1;
    check("ready_after_rst", 32'(s_ready), 32'd1);

    // Test 1: fixed frame, sustained bytes, write timing; boundary pulse during last write ignored
    frm = '{8'hFF, 8'h80, 8'h04, 8'h12, 8'h34, 8'h56,
            8'h9A, 8'hBC, 8'hDE, 8'h01, 8'h7F, 8'hFE};
    we_cyc_q.delete();
    base = n_done;
    send_range(0, 11, 1'b1);
    check("t1_we_in_last_cycle", 32'(fb_we), 32'd1);
    pulse_disp();
    check("t1_early_pulse_sel", 32'(fb_selection), 32'd0);
    check("t1_early_pulse_done", 32'(n_done - base), 32'd0);
    check("t1_ready_low", 32'(s_ready), 32'd0);
    check("t1_we_count", 32'(we_cyc_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < we_cyc_q.size(); i++)
      check("t1_we_cycle", 32'(we_cyc_q[i] - sof_cyc), 32'(3 * (i + 1)));

    // Test 2: swap on boundary pulse
    pulse_disp();
    check("t2_done", 32'(frame_done), 32'd1);
    check("t2_sel", 32'(fb_selection), 32'd1);
    check("t2_ready", 32'(s_ready), 32'd1);
    @(posedge sys_clk); #1;
    check("t2_done_1cyc", 32'(frame_done), 32'd0);

    // Test 3: bytes without SOF in IDLE are dropped, then a frame and swap back
    base = n_we;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("t3_ready", 32'(s_ready), 32'd1);
    check("t3_no_we", 32'(n_we - base), 32'd0);
    fill_random();
    send_range(0, 11, 1'b1);
    @(posedge sys_clk); #1;
    check("t3_ready_low", 32'(s_ready), 32'd0);
    pulse_disp();
    check("t3_sel", 32'(fb_selection), 32'd0);

    // Test 4: SOF mid-frame aborts and restarts at pixel 0
    fill_random();
    base = n_err_sof;
    send_range(0, 4, 1'b1);
    fill_random();
    send_range(0, 11, 1'b1);
    @(posedge sys_clk); #1;
    check("t4_err_pulses", 32'(n_err_sof - base), 32'd1);
    base = n_done;
    pulse_disp();
    check("t4_sel", 32'(fb_selection), 32'd1);
    pulse_disp();
    @(posedge sys_clk); #1;
    check("t4_one_swap", 32'(n_done - base), 32'd1);
    check("t4_sel_kept", 32'(fb_selection), 32'd1);

    // Test 6: boundary pulse mid-frame ignored; reset in SWAP_WAIT
    fill_random();
    base = n_done;
    send_range(0, 3, 1'b1);
    pulse_disp();
    check("t6_pulse_ignored_sel", 32'(fb_selection), 32'd1);
    check("t6_pulse_ignored_done", 32'(n_done - base), 32'd0);
    send_range(4, 11, 1'b0);
    @(posedge sys_clk); #1;
    check("t6_in_swap_wait", 32'(s_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(posedge sys_clk); #1;
    check("t6_ready_after_rst", 32'(s_ready), 32'd1);

    // Test 5: random valid gaps over a full frame
    fill_random();
    base = n_we;
    gaps = 1'b1;
    send_range(0, 11, 1'b1);
    gaps = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("t5_we_count", 32'(n_we - base), 32'd4);
    check("t5_ready_low", 32'(s_ready), 32'd0);
    pulse_disp();
    check("t5_sel", 32'(fb_selection), 32'd1);

    repeat (3) @(posedge sys_clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
